// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator result transmit path.
// TX_PARITY_EN selects whether frames carry an even-parity bit.
package calc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } tx_state_t;

  localparam logic TX_IDLE_LVL  = 1'b1;
  localparam logic TX_START_LVL = 1'b0;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_BIT_CYC = 4;

  // Even parity over a zero-extended word (callers must keep words <= 64 bits).
  function automatic logic calc_even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Serial bit-period timer: bit_tick marks the last cycle of each BIT_CYC-cycle bit.
// A restart strobe aligns the period to the edge where a new state is entered.
module tx_bit_timer
  import calc_pkg::*;
#(
  parameter int BIT_CYC = DEF_BIT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_tick
);

  localparam int CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYC - 1);

  logic [CNT_W-1:0] cnt_r;

  // Cycle counter, wrapping at the bit period so consecutive data bits need no restart.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (restart || (cnt_r == LAST_CNT)) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign bit_tick = (cnt_r == LAST_CNT);

endmodule

// File: rtl/result_tx_sequencer.sv
// Frames and shifts one result word out LSB first: start, data, [parity], stop.
// Define TX_PARITY_EN to insert an even-parity bit before the stop bit.
module result_tx_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BIT_CYC = DEF_BIT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              tx_dat,
  output logic              tx_out,
  output logic              tx_done,
  output logic              busy,
  output logic              load_err
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_t         state_r, state_s;
  logic [DATA_W-1:0] shift_r, shift_s;
  logic [IDX_W-1:0]  idx_r, idx_s;
  logic              loaded_r, loaded_s;
  logic              tx_out_s, tx_done_s, busy_s, load_err_s;
  logic              restart_s, bit_tick_s;
`ifdef TX_PARITY_EN
  logic              parity_r, parity_s;
`endif

  assign restart_s = (state_s != state_r);

  tx_bit_timer #(.BIT_CYC(BIT_CYC)) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (restart_s),
    .bit_tick(bit_tick_s)
  );

  // Next state, datapath updates and next output levels.
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    idx_s      = idx_r;
    loaded_s   = loaded_r;
    tx_out_s   = TX_IDLE_LVL;
    tx_done_s  = 1'b0;
    busy_s     = 1'b1;
    load_err_s = p_load && (state_r != IDLE);
`ifdef TX_PARITY_EN
    parity_s   = parity_r;
`endif
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (p_load) begin
          shift_s  = data_in;
          loaded_s = 1'b1;
        end else begin
          shift_s  = shift_r;
        end
        // A same-cycle load starts the frame with the new word.
        if (tx_dat && (loaded_r || p_load)) begin
          state_s  = START;
          loaded_s = 1'b0;
          idx_s    = {IDX_W{1'b0}};
          tx_out_s = TX_START_LVL;
          busy_s   = 1'b1;
`ifdef TX_PARITY_EN
          parity_s = calc_even_parity(64'(p_load ? data_in : shift_r));
`endif
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        tx_out_s = TX_START_LVL;
        if (bit_tick_s) begin
          state_s  = DATA;
          tx_out_s = shift_r[0];
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        tx_out_s = shift_r[0];
        if (bit_tick_s) begin
          shift_s = shift_r >> 1;
          if (idx_r == LAST_IDX) begin
`ifdef TX_PARITY_EN
            state_s  = PARITY;
            tx_out_s = parity_r;
`else
            state_s  = STOP;
            tx_out_s = TX_IDLE_LVL;
`endif
          end else begin
            idx_s    = idx_r + IDX_W'(1);
            tx_out_s = shift_s[0];
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        tx_out_s = parity_r;
        if (bit_tick_s) begin
          state_s  = STOP;
          tx_out_s = TX_IDLE_LVL;
        end else begin
          state_s = PARITY;
        end
      end
`endif
      STOP: begin
        tx_out_s = TX_IDLE_LVL;
        if (bit_tick_s) begin
          state_s   = DONE;
          tx_done_s = 1'b1;
        end else begin
          state_s = STOP;
        end
      end
      DONE: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      shift_r  <= {DATA_W{1'b0}};
      idx_r    <= {IDX_W{1'b0}};
      loaded_r <= 1'b0;
      tx_out   <= TX_IDLE_LVL;
      tx_done  <= 1'b0;
      busy     <= 1'b0;
      load_err <= 1'b0;
`ifdef TX_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      shift_r  <= shift_s;
      idx_r    <= idx_s;
      loaded_r <= loaded_s;
      tx_out   <= tx_out_s;
      tx_done  <= tx_done_s;
      busy     <= busy_s;
      load_err <= load_err_s;
`ifdef TX_PARITY_EN
      parity_r <= parity_s;
`endif
    end
  end

endmodule
